store_buffer: RTL and testbench

//  Write-side counterpart of the load-data extractor. Accepts store ops (sb/sh/sw) from the execute stage
//  and aligns them into a word address, replicated write data and a byte-enable strobe.

---
 rtl/store_buffer_pkg.sv | 45 ++++
 rtl/store_align.sv | 37 +++
 rtl/store_buffer.sv | 129 ++++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store op encoding, byte-enable constants,
// aligned memory-write request and the bundled in/out views of the top level.
package store_buffer_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_SB   = 2'b00,
    OP_SH   = 2'b01,
    OP_SW   = 2'b10,
    OP_RSVD = 2'b11
  } st_op_e;

  localparam logic [3:0] WSTRB_B0 = 4'h1;
  localparam logic [3:0] WSTRB_LO = 4'h3;
  localparam logic [3:0] WSTRB_HI = 4'hC;
  localparam logic [3:0] WSTRB_W  = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_wreq_t;

  typedef struct packed {
    logic        valid;
    st_op_e      op;
    logic [31:0] addr;
    logic [31:0] sdata;
  } store_buffer_in_type;

  typedef struct packed {
    logic      ready;
    logic      exc;
    logic      empty;
    logic      mem_valid;
    mem_wreq_t req;
  } store_buffer_out_type;

endpackage

// File: rtl/store_align.sv
// Turns a right-justified store (op, byte address, data) into a word-aligned
// write request with replicated data and byte enables; flags illegal stores.
module store_align
  import store_buffer_pkg::*;
(
  input  st_op_e      op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  output mem_wreq_t   req_o,
  output logic        misalign_o
);

  always_comb begin
    req_o.addr  = {addr_i[31:2], 2'b00};
    req_o.wdata = sdata_i;
    req_o.wstrb = WSTRB_W;
    misalign_o  = 1'b0;
    unique case (op_i)
      OP_SB: begin
        req_o.wstrb = WSTRB_B0 << addr_i[1:0];
        req_o.wdata = {4{sdata_i[7:0]}};
      end
      OP_SH: begin
        req_o.wstrb = addr_i[1] ? WSTRB_HI : WSTRB_LO;
        req_o.wdata = {2{sdata_i[15:0]}};
        misalign_o  = addr_i[0];
      end
      OP_SW: begin
        misalign_o = (addr_i[1:0] != 2'b00);
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Aligns execute-stage stores, queues them in a small FIFO and drains the FIFO
// head to data memory over a registered valid/ready request.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_sdata,
  output logic        st_ready,
  output logic        st_exc,
  output logic        store_empty,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  store_buffer_in_type  in_s;
  store_buffer_out_type out_s;

  mem_wreq_t    aligned;
  logic         misalign;
  mem_wreq_t    fifo_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [AW:0]  count_q, count_d;
  drain_state_e state_q, state_d;
  mem_wreq_t    req_q, req_d;
  logic         st_exc_q;
  logic         offered, push, pop;

  assign in_s = '{valid: st_valid, op: st_op_e'(st_op), addr: st_addr, sdata: st_sdata};

  store_align u_align (
    .op_i      (in_s.op),
    .addr_i    (in_s.addr),
    .sdata_i   (in_s.sdata),
    .req_o     (aligned),
    .misalign_o(misalign)
  );

  assign offered  = in_s.valid && (count_q != FULL_CNT);
  assign push     = offered && !misalign;
  assign pop      = (state_q == S_REQ) && mem_ready;
  assign rptr_nxt = rptr_q + 1'b1;

  // The presented request stays counted until its handshake, so a full FIFO
  // includes the entry currently on the memory port.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_REQ;
          req_d   = fifo_q[rptr_q];
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (count_q > ONE_CNT) begin
            req_d = fifo_q[rptr_nxt];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      st_exc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      count_q  <= count_d;
      st_exc_q <= offered && misalign;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_nxt;
    end
  end

  // Storage carries no reset so it can map onto plain RAM/registers.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wptr_q] <= aligned;
  end

  always_comb begin
    out_s.ready     = (count_q != FULL_CNT);
    out_s.exc       = st_exc_q;
    out_s.mem_valid = (state_q == S_REQ);
    out_s.empty     = (count_q == '0) && (state_q != S_REQ);
    out_s.req       = req_q;
  end

  assign st_ready    = out_s.ready;
  assign st_exc      = out_s.exc;
  assign store_empty = out_s.empty;
  assign mem_valid   = out_s.mem_valid;
  assign mem_addr    = out_s.req.addr;
  assign mem_wdata   = out_s.req.wdata;
  assign mem_wstrb   = out_s.req.wstrb;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, exceptions, backpressure,
// pointer wrap under continuous push/pop, and reset mid-drain.
module tb_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr, st_sdata;
  logic        st_ready, st_exc, store_empty;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_op      (st_op),
    .st_addr    (st_addr),
    .st_sdata   (st_sdata),
    .st_ready   (st_ready),
    .st_exc     (st_exc),
    .store_empty(store_empty),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_sdata = d;
    cyc();
    st_valid = 1'b0;
  endtask

  // Waits (bounded) for a request, checks it, then lets the handshake complete.
  task automatic expect_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int max_wait);
    int w = 0;
    while (!mem_valid && w < max_wait) begin
      cyc();
      w++;
    end
    chk({tag, "_valid"}, 32'(mem_valid), 32'd1);
    chk({tag, "_addr"},  mem_addr, a);
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(s));
    $display("txn %s addr=%h wdata=%h wstrb=%h", tag, mem_addr, mem_wdata, mem_wstrb);
    cyc();
  endtask

  initial begin
    reset     = 1'b1;
    st_valid  = 1'b0;
    st_op     = 2'b00;
    st_addr   = '0;
    st_sdata  = '0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_st_exc",    32'(st_exc), 32'd0);
    chk("rst_empty",     32'(store_empty), 32'd1);
    chk("rst_st_ready",  32'(st_ready), 32'd1);

    // 1: byte store in the top lane
    mem_ready = 1'b1;
    push_one(2'b00, 32'h0000_1003, 32'h0000_00AB);
    chk("t1_not_empty", 32'(store_empty), 32'd0);
    expect_req("t1_sb", 32'h0000_1000, 32'hABAB_ABAB, 4'h8, 4);
    chk("t1_drained_valid", 32'(mem_valid), 32'd0);
    chk("t1_drained_empty", 32'(store_empty), 32'd1);

    // 2: halfword stores, upper then lower half
    push_one(2'b01, 32'h0000_2002, 32'h0000_1234);
    expect_req("t2_sh_hi", 32'h0000_2000, 32'h1234_1234, 4'hC, 4);
    push_one(2'b01, 32'h0000_2000, 32'h0000_BEEF);
    expect_req("t2_sh_lo", 32'h0000_2000, 32'hBEEF_BEEF, 4'h3, 4);
    push_one(2'b00, 32'h0000_2005, 32'hFFFF_FF5A);
    expect_req("t2_sb_b1", 32'h0000_2004, 32'h5A5A_5A5A, 4'h2, 4);

    // 3: misaligned word and reserved op are dropped with a one-cycle pulse
    push_one(2'b10, 32'h0000_3001, 32'h1111_1111);
    chk("t3_sw_exc", 32'(st_exc), 32'd1);
    chk("t3_sw_valid", 32'(mem_valid), 32'd0);
    cyc();
    chk("t3_sw_exc_end", 32'(st_exc), 32'd0);
    chk("t3_sw_empty", 32'(store_empty), 32'd1);
    push_one(2'b11, 32'h0000_3000, 32'h2222_2222);
    chk("t3_rsvd_exc", 32'(st_exc), 32'd1);
    cyc();
    chk("t3_rsvd_exc_end", 32'(st_exc), 32'd0);
    chk("t3_rsvd_valid", 32'(mem_valid), 32'd0);
    chk("t3_rsvd_empty", 32'(store_empty), 32'd1);
    push_one(2'b01, 32'h0000_3003, 32'h3333_3333);
    chk("t3_sh_exc", 32'(st_exc), 32'd1);
    cyc();
    chk("t3_sh_empty", 32'(store_empty), 32'd1);

    // 4: fill under backpressure, then drain back to back
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(2'b10, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    chk("t4_full_ready", 32'(st_ready), 32'd0);
    chk("t4_head_addr", mem_addr, 32'h0000_0010);
    push_one(2'b10, 32'h0000_0020, 32'hDEAD_BEEF);
    cyc();
    chk("t4_frozen_addr", mem_addr, 32'h0000_0010);
    chk("t4_frozen_wdata", mem_wdata, 32'hA000_0000);
    chk("t4_frozen_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    chk("t4_full_pop_ready", 32'(st_ready), 32'd0);
    expect_req("t4_d0", 32'h0000_0010, 32'hA000_0000, 4'hF, 0);
    chk("t4_slot_freed", 32'(st_ready), 32'd1);
    expect_req("t4_d1", 32'h0000_0014, 32'hA000_0001, 4'hF, 0);
    expect_req("t4_d2", 32'h0000_0018, 32'hA000_0002, 4'hF, 0);
    expect_req("t4_d3", 32'h0000_001C, 32'hA000_0003, 4'hF, 0);
    chk("t4_done_valid", 32'(mem_valid), 32'd0);
    chk("t4_done_empty", 32'(store_empty), 32'd1);

    // 5: continuous stream, push and pop each cycle across several wraps
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          st_valid = 1'b1;
          st_op    = 2'b10;
          st_addr  = 32'h100 + 32'(4 * i);
          st_sdata = 32'h5000_0000 + 32'(i);
          cyc();
          chk("t5_ready", 32'(st_ready), 32'd1);
        end
        st_valid = 1'b0;
      end
      begin
        int k = 0;
        for (int t = 0; t < 40 && k < 12; t++) begin
          cyc();
          if (mem_valid) begin
            chk("t5_addr", mem_addr, 32'h100 + 32'(4 * k));
            chk("t5_wdata", mem_wdata, 32'h5000_0000 + 32'(k));
            $display("txn t5_%0d addr=%h wdata=%h", k, mem_addr, mem_wdata);
            k++;
          end
        end
        chk("t5_count", 32'(k), 32'd12);
      end
    join
    cyc();
    chk("t5_empty", 32'(store_empty), 32'd1);

    // 6: reset while draining discards everything
    mem_ready = 1'b0;
    push_one(2'b10, 32'h0000_0040, 32'hC000_0000);
    push_one(2'b10, 32'h0000_0044, 32'hC000_0001);
    push_one(2'b10, 32'h0000_0048, 32'hC000_0002);
    chk("t6_pre_valid", 32'(mem_valid), 32'd1);
    chk("t6_pre_addr", mem_addr, 32'h0000_0040);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_valid", 32'(mem_valid), 32'd0);
    chk("t6_empty", 32'(store_empty), 32'd1);
    chk("t6_ready", 32'(st_ready), 32'd1);
    mem_ready = 1'b1;
    begin
      int seen = 0;
      for (int t = 0; t < 6; t++) begin
        cyc();
        if (mem_valid) seen++;
      end
      chk("t6_no_stale", 32'(seen), 32'd0);
    end
    push_one(2'b00, 32'h0000_0050, 32'h0000_0077);
    expect_req("t6_after", 32'h0000_0050, 32'h7777_7777, 4'h1, 4);
    chk("t6_final_empty", 32'(store_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
